// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM stage register: 2-entry skid buffer with valid/ready on both sides and flush.
// Optional saturating stall counter enabled by defining EX_MEM_STALL_COUNT_EN.
module ex_mem_pipe_reg #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      RegWriteIn,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegisterIn,
  input  logic [DATA_WIDTH-1:0]     ALUResultIn,
  input  logic                      Flush,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      RegWriteOut,
  output logic [REG_ADDR_WIDTH-1:0] WriteRegisterOut,
  output logic [DATA_WIDTH-1:0]     ALUResultOut
`ifdef EX_MEM_STALL_COUNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] StallCount
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]                state_reg, state_next;
  logic                      head_rw_reg, skid_rw_reg;
  logic [REG_ADDR_WIDTH-1:0] head_wr_reg, skid_wr_reg;
  logic [DATA_WIDTH-1:0]     head_alu_reg, skid_alu_reg;

  logic push, pop;
  logic load_head_in, load_skid_in, move_skid;

  // Ready and valid come straight from the state register, so OutReady never reaches InReady.
  assign InReady  = (state_reg != TWO);
  assign OutValid = (state_reg != EMPTY);
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;

  assign RegWriteOut      = head_rw_reg & OutValid;
  assign WriteRegisterOut = head_wr_reg;
  assign ALUResultOut     = head_alu_reg;

  always_comb begin
    state_next   = state_reg;
    load_head_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    if (Flush) begin
      // A same-cycle push is dropped; a same-cycle pop has already been consumed downstream.
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next   = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_head_in = 1'b1;
          end else if (push) begin
            state_next   = TWO;
            load_skid_in = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_next = ONE;
            move_skid  = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_reg    <= EMPTY;
      head_rw_reg  <= 1'b0;
      head_wr_reg  <= '0;
      head_alu_reg <= '0;
      skid_rw_reg  <= 1'b0;
      skid_wr_reg  <= '0;
      skid_alu_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_head_in) begin
        head_rw_reg  <= RegWriteIn;
        head_wr_reg  <= WriteRegisterIn;
        head_alu_reg <= ALUResultIn;
      end else if (move_skid) begin
        head_rw_reg  <= skid_rw_reg;
        head_wr_reg  <= skid_wr_reg;
        head_alu_reg <= skid_alu_reg;
      end
      if (load_skid_in) begin
        skid_rw_reg  <= RegWriteIn;
        skid_wr_reg  <= WriteRegisterIn;
        skid_alu_reg <= ALUResultIn;
      end
    end
  end

`ifdef EX_MEM_STALL_COUNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_reg;

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      stall_cnt_reg <= '0;
    end else if (OutValid && !OutReady && !(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign StallCount = stall_cnt_reg;
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = (STALL_CNT_WIDTH > 0);
`endif

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX/MEM pipeline stage register. It carries the destination register index, the ALU result and the RegWrite control bit from EX to MEM. Both sides use a valid/ready handshake, and a 2-entry skid buffer registers every path, so no combinational path runs from OutReady to InReady. It adds back-pressure, flush and bubble tracking. It is the drop-in successor for the fixed-width EX/MEM latch, and all stage registers in the pipeline are built from it.

## Interface
Parameters:
- DATA_WIDTH, 32, width of ALUResult
- REG_ADDR_WIDTH, 5, width of the destination register index
- STALL_CNT_WIDTH, 16, width of the stall counter (only with the macro)

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- ResetN  in  1  reset, synchronous, active-low
- InValid  in  1  EX presents a valid entry
- InReady  out  1  stage can accept an entry this cycle
- RegWriteIn  in  1  write-enable control bit
- WriteRegisterIn  in  REG_ADDR_WIDTH  destination register index
- ALUResultIn  in  DATA_WIDTH  ALU result
- Flush  in  1  discard all held entries (branch/exception)
- OutValid  out  1  MEM-side entry valid
- OutReady  in  1  MEM accepts the entry
- RegWriteOut  out  1  RegWrite of the head entry, ANDed with OutValid
- WriteRegisterOut  out  REG_ADDR_WIDTH  head destination index
- ALUResultOut  out  DATA_WIDTH  head ALU result
- StallCount  out  STALL_CNT_WIDTH  saturating stall counter (only with the macro)

## Operation
- Storage: a head entry drives the outputs; a skid entry holds overflow. Each entry has a valid bit.
- States:
  - EMPTY: neither entry valid.
  - ONE: head valid only.
  - TWO: head and skid valid.
- Signal definitions:
  - InReady = (state != TWO). It is derived only from registered state.
  - OutValid = head valid.
  - push = InValid & InReady.
  - pop = OutValid & OutReady.
- Transitions with no flush:
  - EMPTY: push → ONE (head ← input).
  - ONE, push & pop: stay ONE (head ← input).
  - ONE, push & !pop: → TWO (skid ← input).
  - ONE, !push & pop: → EMPTY.
  - TWO, pop: → ONE (head ← skid). No push is possible in TWO.
  - Any state with no push and no pop holds.
- Ordering is strict FIFO; no entry is dropped or duplicated except by Flush.
- Flush has priority over everything. At the edge, both valid bits clear and the state goes to EMPTY. A push in the same cycle is discarded. A pop in the same cycle completes normally, because MEM has already sampled the data.
- Data registers:
  - They load only on a push or a skid→head move.
  - Invalid entries keep stale data. RegWriteOut is still forced to 0 by the OutValid gating.
- While OutValid = 1 and OutReady = 0, all outputs stay stable until the pop.

## Timing
- Reset: ResetN sampled low at a rising edge puts the block into state EMPTY. After that edge:
  - OutValid = 0, RegWriteOut = 0, WriteRegisterOut = 0, ALUResultOut = 0.
  - InReady = 1, StallCount = 0.
  - Inputs are ignored while ResetN is low.
- Reset mid-operation: held entries are lost, exactly like a flush. The data registers also clear to 0.
- Latency: an entry pushed at edge k is at the outputs after edge k (one cycle) when the stage was EMPTY, or ONE with a simultaneous pop.
- Throughput: one entry per cycle while OutReady = 1.
- Back-pressure: InReady reflects a stall one cycle after it begins. The skid entry absorbs the in-flight push.
- No combinational path exists:
  - from any input to any output;
  - from OutReady to InReady.

## Configuration
- EX_MEM_STALL_COUNT_EN
  - Defined: StallCount exists. It increments by 1 on each edge where OutValid & !OutReady, and saturates at all-ones (no wrap). Reset clears it; Flush does not.
  - Undefined: the StallCount port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then push {RegWrite=1, WR=5, ALU=0xDEADBEEF} with OutReady=1 → one edge later OutValid=1, RegWriteOut=1, WriteRegisterOut=5, ALUResultOut=0xDEADBEEF; next edge OutValid=0.
- Stream 8 entries (ALU=1..8) with OutReady=1 every cycle → 8 consecutive output cycles, values 1..8 in order, InReady=1 throughout.
- Push 1,2,3 with OutReady=0 from the start → after 2 pushes state TWO and InReady=0; entry 3 is held off. Raise OutReady → outputs 1,2,3 in order, nothing lost. With the macro, StallCount equals the number of stalled cycles.
- Hold state TWO, assert Flush with InValid=1 → next edge OutValid=0, RegWriteOut=0, InReady=1, and the flushed-cycle input never appears.
- Drive ResetN low for one edge while in state TWO → OutValid=0, all data outputs 0, InReady=1, StallCount=0.
- With the macro and STALL_CNT_WIDTH=4, stall for 20 cycles → StallCount stops at 15.
